wb_load_align: RTL and testbench
================================

# wb_load_align

Parametrised writeback stage for the pipelined CPU. Holds the MEM/WB pipeline register and formats load data from the synchronous data RAM. Supports sub-word loads, unaligned merges (lwl/lwr), 64-bit loads, stall/flush control and misaligned-address detection with a sticky exception record. It drives the register-file write port (data, address, enable) and the forwarding path.

## Interface
Parameters:
- DATA_W, 32: datapath width; legal values 32 and 64.
- REG_AW, 5: register address width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous, active-low reset.
- stallW  in  1  hold the WB register.
- flushW  in  1  load a bubble into the WB register.
- validM  in  1  MEM-stage instruction valid.
- RegWriteM  in  1  instruction writes a register.
- MemtoRegM  in  1  result comes from memory.
- opM  in  6  primary opcode.
- waM  in  REG_AW  destination register.
- alu_outM  in  DATA_W  ALU result or effective address.
- rt_oldM  in  DATA_W  old destination value, used by lwl/lwr.
- doutbW  in  DATA_W  RAM read data, valid in W (RAM address presented in M).
- exc_ack  in  1  clears the sticky exception.
- RegWriteW  out  1  register-file write enable.
- waW  out  REG_AW  write address.
- r3_dinW  out  DATA_W  write data.
- addr_excW  out  1  misaligned load in W; combinational from the WB register.
- exc_pending  out  1  sticky exception flag.
- badvaddr  out  DATA_W  address of the first unacknowledged misaligned load.

## Operation
- WB register fields: valid, RegWrite, MemtoReg, op, wa, alu_out, rt_old.
- Update priority on each clk edge: reset, then flushW (valid=0, RegWrite=0; other fields don't-care), then stallW (hold), then load from M.
- Non-load instructions (MemtoReg=0): r3_dinW = alu_out.
- Load formatting, little-endian. For DATA_W=32, a = addr[1:0]. For DATA_W=64, a = addr[2:0], and word loads select the half addressed by addr[2].
- lw 0x23: the addressed 32-bit word. For DATA_W=64, sign-extend it.
- lb 0x20 / lbu 0x24: the byte at lane a, sign- or zero-extended.
- lh 0x21 / lhu 0x25: the halfword at lane a>>1, sign- or zero-extended.
- lwl 0x22, with b = addr[1:0]: result = (word << 8·(3−b)) | (rt_old[31:0] & low mask of 8·(3−b) bits).
- lwr 0x26, with b = addr[1:0]: result = (word >> 8·b) | (rt_old[31:0] & high mask of 8·b bits).
- lwl/lwr results: sign-extend bit 31 when DATA_W=64.
- lwu 0x27 and ld 0x37: only when DATA_W=64 (zero-extended word; full 64-bit). When DATA_W=32 they behave as lw.
- Any other opcode with MemtoReg=1: r3_dinW = doutbW.
- Misalignment checks:
  - lh/lhu: addr[0] ≠ 0.
  - lw/lwu: addr[1:0] ≠ 0.
  - ld: addr[2:0] ≠ 0.
  - lb, lbu, lwl and lwr never fault.
- addr_excW = valid & MemtoReg & misaligned.
- RegWriteW = valid & RegWrite & ~addr_excW.
- Sticky exception record:
  - When addr_excW=1, stallW=0 and exc_pending=0: set exc_pending and capture badvaddr = alu_out.
  - Later faults while exc_pending=1 do not overwrite badvaddr.
  - exc_ack clears exc_pending. If exc_ack coincides with a new fault, the new fault sets exc_pending and captures its address (set wins).

## Timing
- Latency: values sampled at edge N appear on W outputs after edge N; r3_dinW is combinational on doutbW within that cycle.
- Reset values: RegWriteW=0, waW=0, r3_dinW=0 (alu_out=0, MemtoReg=0), addr_excW=0, exc_pending=0, badvaddr=0.
- Stall: outputs are held, but RegWriteW stays asserted. The register file tolerates a rewrite of the same value, so no write is lost or duplicated in effect.
- A flush asserted together with a stall produces a bubble.
- Reset overrides everything, including an in-flight load.
- Write-port and forwarding consumers see the same r3_dinW.

## Structure
- Shared package `cpu_pkg`: opcode localparams (OP_LB…OP_LD), DATA_W legality check.
- One sub-module `load_fmt`: combinational extraction/merge, parametrised by DATA_W.
- Top level: pipeline register, exception logic, `load_fmt` instance.

## Test plan
- Byte loads, DATA_W=32, doutbW=0x80FF7F01:
  - lb at addr 0..3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - lbu at addr 3 → 0x00000080.
- lh at addr 0x2 with doutbW=0x8001_1234 → 0xFFFF8001.
- lh at addr 0x1 → addr_excW=1, RegWriteW=0, exc_pending=1, badvaddr=0x1.
- A second fault at 0x3 leaves badvaddr=0x1. exc_ack clears exc_pending.
- lwl/lwr, word=0xAABBCCDD, rt_old=0x11223344:
  - lwl at b=1 → 0xCCDD3344.
  - lwr at b=1 → 0x11AABBCC.
- Pipeline control:
  - stallW for 3 cycles holds waW/r3_dinW.
  - flushW in the same cycle as stallW → RegWriteW=0 next cycle.
  - rst_n low mid-stream → all outputs 0 next cycle.
- DATA_W=64, doutbW=0x89ABCDEF_01234567:
  - ld at addr 0 → full value.
  - lw at addr 4 → 0xFFFFFFFF89ABCDEF.
  - lwu at addr 4 → 0x0000000089ABCDEF.
  - ld at addr 4 → exception.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load opcodes and datapath width legality.
package cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_LWU = 6'h27;
  localparam logic [5:0] OP_LD  = 6'h37;

  // Only 32- and 64-bit datapaths are supported.
  function automatic bit data_w_legal(input int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/load_fmt.sv
// Load data extraction/merge and misalignment detection (combinational).
module load_fmt
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [5:0]        op_i,
  input  logic [2:0]        addr_i,
  input  logic [31:0]       rt_old_i,
  input  logic [DATA_W-1:0] dout_i,
  output logic [DATA_W-1:0] result_c,
  output logic              misalign_c
);

  localparam bit          IS64   = (DATA_W == 64);
  localparam int unsigned LANE_W = IS64 ? 3 : 2;

  logic [LANE_W-1:0] lane;
  logic [1:0]        b;
  logic [4:0]        lwl_sh;
  logic [4:0]        lwr_sh;
  logic [31:0]       word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       lwl_v;
  logic [31:0]       lwr_v;
  logic [5:0]        eff_op;

  // Lane selection, merge values and opcode-driven result mux.
  always_comb begin
    lane       = addr_i[LANE_W-1:0];
    b          = addr_i[1:0];
    lwl_sh     = {~b, 3'b000};
    lwr_sh     = {b, 3'b000};
    word       = (IS64 && addr_i[2]) ? dout_i[DATA_W-1 -: 32] : dout_i[31:0];
    byte_v     = 8'(dout_i >> {lane, 3'b000});
    half_v     = 16'(dout_i >> {lane[LANE_W-1:1], 4'b0000});
    lwl_v      = (word << lwl_sh) | (rt_old_i & ((32'd1 << lwl_sh) - 32'd1));
    lwr_v      = (word >> lwr_sh) | (rt_old_i & ~(32'hFFFF_FFFF >> lwr_sh));
    eff_op     = op_i;
    if (!IS64 && ((op_i == OP_LWU) || (op_i == OP_LD))) eff_op = OP_LW;

    result_c   = dout_i;
    misalign_c = 1'b0;
    case (eff_op)
      OP_LB:  result_c = DATA_W'($signed(byte_v));
      OP_LBU: result_c = DATA_W'(byte_v);
      OP_LH: begin
        result_c   = DATA_W'($signed(half_v));
        misalign_c = addr_i[0];
      end
      OP_LHU: begin
        result_c   = DATA_W'(half_v);
        misalign_c = addr_i[0];
      end
      OP_LW: begin
        result_c   = DATA_W'($signed(word));
        misalign_c = |addr_i[1:0];
      end
      OP_LWU: begin
        result_c   = DATA_W'(word);
        misalign_c = |addr_i[1:0];
      end
      OP_LD: begin
        result_c   = dout_i;
        misalign_c = |addr_i[2:0];
      end
      OP_LWL:  result_c = DATA_W'($signed(lwl_v));
      OP_LWR:  result_c = DATA_W'($signed(lwr_v));
      default: result_c = dout_i;
    endcase
  end

endmodule

// File: rtl/wb_load_align.sv
// Writeback stage: MEM/WB register, load formatting, sticky misaligned-load record.
module wb_load_align
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallW,
  input  logic              flushW,
  input  logic              validM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [5:0]        opM,
  input  logic [REG_AW-1:0] waM,
  input  logic [DATA_W-1:0] alu_outM,
  input  logic [DATA_W-1:0] rt_oldM,
  input  logic [DATA_W-1:0] doutbW,
  input  logic              exc_ack,
  output logic              RegWriteW,
  output logic [REG_AW-1:0] waW,
  output logic [DATA_W-1:0] r3_dinW,
  output logic              addr_excW,
  output logic              exc_pending,
  output logic [DATA_W-1:0] badvaddr
);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("wb_load_align: DATA_W must be 32 or 64");
  end

  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic              m2r_q, m2r_d;
  logic [5:0]        op_q, op_d;
  logic [REG_AW-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [31:0]       rt_q, rt_d;
  logic              exc_q, exc_d;
  logic [DATA_W-1:0] bad_q, bad_d;
  logic [DATA_W-1:0] fmt_c;
  logic              misalign_c;
  logic              exc_set_c;
  logic              unused_rt_hi;

  // Only the low word of the old destination takes part in lwl/lwr merges.
  assign unused_rt_hi = ^rt_oldM;

  // Pipeline register next state: flush beats stall beats load.
  always_comb begin
    valid_d = valid_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    op_d    = op_q;
    wa_d    = wa_q;
    alu_d   = alu_q;
    rt_d    = rt_q;
    if (flushW) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
    end else if (!stallW) begin
      valid_d = validM;
      rw_d    = RegWriteM;
      m2r_d   = MemtoRegM;
      op_d    = opM;
      wa_d    = waM;
      alu_d   = alu_outM;
      rt_d    = rt_oldM[31:0];
    end
  end

  // Sticky exception: a new fault (set) wins over an acknowledge.
  always_comb begin
    exc_d     = exc_q;
    bad_d     = bad_q;
    exc_set_c = addr_excW & ~stallW & (~exc_q | exc_ack);
    if (exc_set_c) begin
      exc_d = 1'b1;
      bad_d = alu_q;
    end else if (exc_ack) begin
      exc_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      op_q    <= '0;
      wa_q    <= '0;
      alu_q   <= '0;
      rt_q    <= '0;
      exc_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
      op_q    <= op_d;
      wa_q    <= wa_d;
      alu_q   <= alu_d;
      rt_q    <= rt_d;
      exc_q   <= exc_d;
      bad_q   <= bad_d;
    end
  end

  load_fmt #(.DATA_W(DATA_W)) u_load_fmt (
    .op_i      (op_q),
    .addr_i    (alu_q[2:0]),
    .rt_old_i  (rt_q),
    .dout_i    (doutbW),
    .result_c  (fmt_c),
    .misalign_c(misalign_c)
  );

  assign addr_excW   = valid_q & m2r_q & misalign_c;
  assign RegWriteW   = valid_q & rw_q & ~addr_excW;
  assign waW         = wa_q;
  assign r3_dinW     = m2r_q ? fmt_c : alu_q;
  assign exc_pending = exc_q;
  assign badvaddr    = bad_q;

endmodule

// File: tb/tb_wb_load_align.sv
// Bench for wb_load_align: 32- and 64-bit instances share stimulus, checked against a behavioural model.
module tb_wb_load_align;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n, stallW, flushW, validM, RegWriteM, MemtoRegM, exc_ack;
  logic [5:0]  opM;
  logic [4:0]  waM;
  logic [63:0] alu64, rt64, dout64;

  logic        rw32, ae32, ep32, rw64, ae64, ep64;
  logic [4:0]  wa32, wa64;
  logic [31:0] r3_32, bad32;
  logic [63:0] r3_64, bad64;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of the WB register contents (widest form) and per-instance exception record.
  logic        m_valid, m_rw, m_m2r, m_known;
  logic [5:0]  m_op;
  logic [4:0]  m_wa;
  logic [63:0] m_alu, m_rt;
  logic        m_exc[2];
  logic [63:0] m_bad[2];

  logic [5:0] op_tab[12] = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU,
                             OP_LWR, OP_LWU, OP_LD, 6'h00, 6'h2B, 6'h0F};

  wb_load_align #(.DATA_W(32), .REG_AW(5)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .stallW(stallW), .flushW(flushW),
    .validM(validM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .opM(opM), .waM(waM), .alu_outM(alu64[31:0]), .rt_oldM(rt64[31:0]),
    .doutbW(dout64[31:0]), .exc_ack(exc_ack),
    .RegWriteW(rw32), .waW(wa32), .r3_dinW(r3_32), .addr_excW(ae32),
    .exc_pending(ep32), .badvaddr(bad32)
  );

  wb_load_align #(.DATA_W(64), .REG_AW(5)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .stallW(stallW), .flushW(flushW),
    .validM(validM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .opM(opM), .waM(waM), .alu_outM(alu64), .rt_oldM(rt64),
    .doutbW(dout64), .exc_ack(exc_ack),
    .RegWriteW(rw64), .waW(wa64), .r3_dinW(r3_64), .addr_excW(ae64),
    .exc_pending(ep64), .badvaddr(bad64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [63:0] x);
    return x[31] ? (x | 64'hFFFF_FFFF_0000_0000) : x;
  endfunction

  // Load result as the architecture defines it, for a datapath of width w.
  function automatic logic [63:0] model_fmt(input int w, input logic [5:0] op,
                                            input logic [63:0] addr, input logic [63:0] dout,
                                            input logic [63:0] rt, output bit mis);
    logic [63:0] d, word, v, res;
    logic [5:0]  o;
    int a, b, sh;
    d = (w == 32) ? (dout & 64'hFFFF_FFFF) : dout;
    o = op;
    if (w == 32 && (op == OP_LWU || op == OP_LD)) o = OP_LW;
    word = (w == 64 && addr[2]) ? (d >> 32) : (d & 64'hFFFF_FFFF);
    a = (w == 64) ? int'(addr[2:0]) : int'(addr[1:0]);
    b = int'(addr[1:0]);
    mis = 1'b0;
    res = d;
    case (o)
      OP_LB, OP_LBU: begin
        v   = (d >> (8 * a)) & 64'hFF;
        res = (o == OP_LB && v[7]) ? (v | ~64'hFF) : v;
      end
      OP_LH, OP_LHU: begin
        v   = (d >> (16 * (a / 2))) & 64'hFFFF;
        res = (o == OP_LH && v[15]) ? (v | ~64'hFFFF) : v;
        mis = addr[0];
      end
      OP_LW:  begin res = sx32(word); mis = (addr[1:0] != 2'd0); end
      OP_LWU: begin res = word;       mis = (addr[1:0] != 2'd0); end
      OP_LD:  begin res = d;          mis = (addr[2:0] != 3'd0); end
      OP_LWL: begin
        sh  = 8 * (3 - b);
        res = sx32(((word << sh) | (rt & ((64'd1 << sh) - 64'd1))) & 64'hFFFF_FFFF);
      end
      OP_LWR: begin
        sh  = 8 * b;
        res = sx32(((word >> sh) | (rt & ~(64'hFFFF_FFFF >> sh))) & 64'hFFFF_FFFF);
      end
      default: res = d;
    endcase
    if (w == 32) res = res & 64'hFFFF_FFFF;
    return res;
  endfunction

  function automatic bit model_ae(input int w);
    bit mis;
    logic [63:0] r;
    r = model_fmt(w, m_op, m_alu, dout64, m_rt, mis);
    return m_valid && m_m2r && mis && (r == r);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Compare both instances against the model for the current W contents.
  task automatic compare_all();
    logic [63:0] r, mask, exp_r3, g_r3, g_bad;
    logic [4:0]  g_wa;
    logic        g_rw, g_ae, g_ep;
    bit mis, ae;
    int w;
    for (int i = 0; i < 2; i++) begin
      w      = (i == 0) ? 32 : 64;
      mask   = (i == 0) ? 64'hFFFF_FFFF : '1;
      r      = model_fmt(w, m_op, m_alu, dout64, m_rt, mis);
      ae     = m_valid && m_m2r && mis;
      exp_r3 = m_m2r ? r : (m_alu & mask);
      g_rw   = (i == 0) ? rw32 : rw64;
      g_ae   = (i == 0) ? ae32 : ae64;
      g_ep   = (i == 0) ? ep32 : ep64;
      g_wa   = (i == 0) ? wa32 : wa64;
      g_r3   = (i == 0) ? 64'(r3_32) : r3_64;
      g_bad  = (i == 0) ? 64'(bad32) : bad64;
      chk($sformatf("addr_excW/%0d", w), 64'(g_ae), 64'(ae));
      chk($sformatf("RegWriteW/%0d", w), 64'(g_rw), 64'(m_valid && m_rw && !ae));
      chk($sformatf("exc_pending/%0d", w), 64'(g_ep), 64'(m_exc[i]));
      chk($sformatf("badvaddr/%0d", w), g_bad, m_bad[i] & mask);
      if (m_known) begin
        chk($sformatf("waW/%0d", w), 64'(g_wa), 64'(m_wa));
        chk($sformatf("r3_dinW/%0d", w), g_r3, exp_r3);
      end
    end
  endtask

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_update();
    bit ae[2];
    ae[0] = model_ae(32);
    ae[1] = model_ae(64);
    if (!rst_n) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_op = '0; m_wa = '0;
      m_alu = '0; m_rt = '0; m_known = 1;
      for (int i = 0; i < 2; i++) begin m_exc[i] = 0; m_bad[i] = '0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ae[i] && !stallW && (!m_exc[i] || exc_ack)) begin
          m_exc[i] = 1;
          m_bad[i] = m_alu;
        end else if (exc_ack) begin
          m_exc[i] = 0;
        end
      end
      if (flushW) begin
        m_valid = 0; m_rw = 0; m_known = 0;
      end else if (!stallW) begin
        m_valid = validM; m_rw = RegWriteM; m_m2r = MemtoRegM; m_op = opM;
        m_wa = waM; m_alu = alu64; m_rt = rt64; m_known = 1;
      end
    end
  endtask

  task automatic eval_now();
    #1;
    compare_all();
  endtask

  task automatic advance();
    model_update();
    @(negedge clk);
  endtask

  task automatic drive_m(input logic [5:0] op, input logic [4:0] wa,
                         input logic [63:0] alu, input logic [63:0] rt);
    validM = 1; RegWriteM = 1; MemtoRegM = 1;
    opM = op; waM = wa; alu64 = alu; rt64 = rt;
  endtask

  initial begin
    rst_n = 0; stallW = 0; flushW = 0; exc_ack = 0;
    validM = 0; RegWriteM = 0; MemtoRegM = 0;
    opM = '0; waM = '0; alu64 = '0; rt64 = '0; dout64 = '0;
    m_valid = 0; m_rw = 0; m_m2r = 0; m_op = '0; m_wa = '0;
    m_alu = '0; m_rt = '0; m_known = 0;
    for (int i = 0; i < 2; i++) begin m_exc[i] = 0; m_bad[i] = '0; end
    @(negedge clk);
    advance();

    // Reset state, then byte loads
    rst_n = 1;
    drive_m(OP_LB, 5'd1, 64'd0, 64'd0);
    eval_now();
    chk("reset RegWriteW", 64'(rw32), 64'd0);
    chk("reset waW", 64'(wa32), 64'd0);
    chk("reset r3_dinW", 64'(r3_32), 64'd0);
    chk("reset exc_pending", 64'(ep32), 64'd0);
    chk("reset badvaddr", 64'(bad64), 64'd0);
    advance();

    dout64 = 64'h0000_0000_80FF_7F01;
    drive_m(OP_LB, 5'd2, 64'd1, 64'd0);  eval_now(); chk("lb a0", 64'(r3_32), 64'h0000_0001); advance();
    drive_m(OP_LB, 5'd3, 64'd2, 64'd0);  eval_now(); chk("lb a1", 64'(r3_32), 64'h0000_007F); advance();
    drive_m(OP_LB, 5'd4, 64'd3, 64'd0);  eval_now(); chk("lb a2", 64'(r3_32), 64'hFFFF_FFFF); advance();
    drive_m(OP_LBU, 5'd5, 64'd3, 64'd0); eval_now(); chk("lb a3", 64'(r3_32), 64'hFFFF_FF80); advance();
    dout64 = 64'h0000_0000_8001_1234;
    drive_m(OP_LH, 5'd6, 64'd2, 64'd0);  eval_now(); chk("lbu a3", 64'(r3_32), 64'h0000_0080); advance();
    drive_m(OP_LH, 5'd7, 64'd1, 64'd0);  eval_now(); chk("lh a2", 64'(r3_32), 64'hFFFF_8001); advance();
    drive_m(OP_LH, 5'd8, 64'd3, 64'd0);  eval_now();
    chk("lh a1 addr_excW", 64'(ae32), 64'd1);
    chk("lh a1 RegWriteW", 64'(rw32), 64'd0);
    advance();
    drive_m(OP_LW, 5'd9, 64'd0, 64'd0);  eval_now();
    chk("fault1 exc_pending", 64'(ep32), 64'd1);
    chk("fault1 badvaddr", 64'(bad32), 64'd1);
    chk("fault2 addr_excW", 64'(ae32), 64'd1);
    advance();
    exc_ack = 1; dout64 = 64'h0000_0000_AABB_CCDD;
    drive_m(OP_LWL, 5'd10, 64'd1, 64'h0000_0000_1122_3344); eval_now();
    chk("fault2 keeps badvaddr", 64'(bad32), 64'd1);
    chk("lw a0", 64'(r3_32), 64'hAABB_CCDD);
    advance();
    exc_ack = 0;
    drive_m(OP_LWR, 5'd11, 64'd1, 64'h0000_0000_1122_3344); eval_now();
    chk("ack clears exc_pending", 64'(ep32), 64'd0);
    chk("lwl b1", 64'(r3_32), 64'hCCDD_3344);
    advance();

    // Stall holds, flush with stall bubbles
    drive_m(6'h00, 5'd12, 64'h1234_5678, 64'd0); MemtoRegM = 0;
    eval_now(); chk("lwr b1", 64'(r3_32), 64'h11AA_BBCC); advance();
    for (int k = 0; k < 3; k++) begin
      stallW = 1;
      drive_m(OP_LB, 5'(13 + k), 64'(k), 64'd0);
      eval_now();
      chk("stall waW", 64'(wa32), 64'd12);
      chk("stall r3_dinW", 64'(r3_32), 64'h1234_5678);
      chk("stall RegWriteW", 64'(rw32), 64'd1);
      advance();
    end
    stallW = 1; flushW = 1; eval_now(); advance();
    stallW = 0; flushW = 0;
    dout64 = 64'h89AB_CDEF_0123_4567;
    drive_m(OP_LD, 5'd1, 64'd0, 64'd0); eval_now();
    chk("flush+stall RegWriteW/32", 64'(rw32), 64'd0);
    chk("flush+stall RegWriteW/64", 64'(rw64), 64'd0);
    advance();

    // 64-bit loads
    drive_m(OP_LW, 5'd2, 64'd4, 64'd0);  eval_now(); chk("ld a0 /64", r3_64, 64'h89AB_CDEF_0123_4567); advance();
    drive_m(OP_LWU, 5'd3, 64'd4, 64'd0); eval_now(); chk("lw a4 /64", r3_64, 64'hFFFF_FFFF_89AB_CDEF); advance();
    drive_m(OP_LD, 5'd4, 64'd4, 64'd0);  eval_now(); chk("lwu a4 /64", r3_64, 64'h0000_0000_89AB_CDEF); advance();
    drive_m(OP_LB, 5'd5, 64'd0, 64'd0);  eval_now();
    chk("ld a4 addr_excW/64", 64'(ae64), 64'd1);
    chk("ld a4 addr_excW/32", 64'(ae32), 64'd0);
    advance();

    // Reset mid-stream
    rst_n = 0;
    drive_m(OP_LW, 5'd6, 64'd0, 64'd0); eval_now();
    chk("ld a4 exc_pending/64", 64'(ep64), 64'd1);
    chk("ld a4 badvaddr/64", bad64, 64'd4);
    advance();
    rst_n = 1; validM = 0; eval_now();
    chk("rst RegWriteW", 64'(rw32 | rw64), 64'd0);
    chk("rst waW", 64'(wa32 | wa64), 64'd0);
    chk("rst r3_dinW", r3_64 | 64'(r3_32), 64'd0);
    chk("rst exc_pending", 64'(ep32 | ep64), 64'd0);
    chk("rst badvaddr", bad64, 64'd0);
    advance();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      stallW    = ($urandom_range(0, 99) < 20);
      flushW    = ($urandom_range(0, 99) < 8);
      exc_ack   = ($urandom_range(0, 99) < 12);
      validM    = ($urandom_range(0, 99) < 85);
      RegWriteM = ($urandom_range(0, 99) < 80);
      MemtoRegM = ($urandom_range(0, 99) < 70);
      opM       = op_tab[$urandom_range(0, 11)];
      waM       = 5'($urandom);
      alu64     = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 40) alu64[2:0] = 3'd0;
      rt64      = {$urandom, $urandom};
      dout64    = {$urandom, $urandom};
      eval_now();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
